// File: rtl/elixirchip_es1_spu_stream_out.sv
// Drain end of an SPU op pipeline: buffers cke-gated results in a small FIFO,
// presents them as a valid/ready stream and generates the pipeline-wide cke.
module elixirchip_es1_spu_stream_out #(
    parameter int    DATA_BITS  = 8,
    parameter type   data_t     = logic [DATA_BITS-1:0],
    parameter int    DEPTH      = 4,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       cke,
    input  data_t                      s_data,
    input  logic                       s_valid,
    output data_t                      m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR_L = PW'(DEPTH - 1);

    data_t         mem_q [DEPTH];
    data_t         mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          cke_q, cke_d;
    logic          push;
    logic          pop;

    // Upstream side: a result is taken only on an edge where cke was high.
    // Downstream side: a word transfers on an edge where m_valid && m_ready;
    // m_valid/m_data depend on registered state only, never on m_ready.
    assign push = cke_q && s_valid;
    assign pop  = (level_q != '0) && m_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_data;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR_L) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR_L) ? '0 : rd_ptr_q + 1'b1;
        end
        level_d = level_q + LW'(push) - LW'(pop);
        // Registered cke: a high cke always leaves room for one more push.
        cke_d   = level_d < DEPTH_L;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cke_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cke_q    <= cke_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cke     = cke_q;
    assign level   = level_q;
    assign m_valid = (level_q != '0);
    assign m_data  = m_valid ? mem_q[rd_ptr_q] : data_t'(0);

    if (SIMULATION == "true") begin : g_sim_checks
        always_ff @(posedge clk) begin
            if (!reset) begin
                assert (!(push && level_q == DEPTH_L))
                    else $error("stream_out: push while full");
                assert (!(pop && level_q == '0))
                    else $error("stream_out: pop while empty");
                assert (DEVICE == "RTL" || DEVICE == "ULTRASCALE_PLUS")
                    else $error("stream_out: unknown DEVICE");
            end
        end
    end

    if (DEBUG == "true") begin : g_debug_checks
        always_ff @(posedge clk) begin
            if (!reset) begin
                assert (!(cke_q && level_q == DEPTH_L))
                    else $error("stream_out: cke high while full");
            end
        end
    end

endmodule

// File: tb/tb_elixirchip_es1_spu_stream_out.sv
// Bench for elixirchip_es1_spu_stream_out: queue-based model checked every cycle,
// plus directed scenarios with hand-computed output sequences.
module tb_elixirchip_es1_spu_stream_out;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cke;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [LW-1:0] level;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  elixirchip_es1_spu_stream_out #(
    .DATA_BITS (DW),
    .DEPTH     (DEPTH),
    .DEVICE    ("RTL"),
    .SIMULATION("true"),
    .DEBUG     ("true")
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cke    (cke),
    .s_data (s_data),
    .s_valid(s_valid),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .level  (level)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: contents as a queue, cke from the occupancy rule
  logic [DW-1:0] exp_q[$];
  bit            cke_m = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      cke_m = 1'b0;
    end else begin
      if (exp_q.size() != 0 && m_ready) void'(exp_q.pop_front());
      if (cke_m && s_valid) exp_q.push_back(s_data);
      cke_m = (exp_q.size() < DEPTH);
    end
  end

  // compare process, plus a log of words the DUT actually handed over
  logic [DW-1:0] out_log[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", int'(m_valid), (exp_q.size() != 0) ? 1 : 0);
      check("level", int'(level), exp_q.size());
      check("cke", int'(cke), int'(cke_m));
      check("m_data", int'(m_data), (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
      if (m_valid && m_ready) out_log.push_back(m_data);
    end
  end

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, '0, r);
  endtask

  task automatic check_log(input string name, input logic [DW-1:0] exp[$]);
    check({name, "_count"}, out_log.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < out_log.size()) check({name, "_word"}, int'(out_log[i]), int'(exp[i]));
    end
    out_log.delete();
  endtask

  initial begin
    logic [DW-1:0] exp_seq[$];

    // 1: reset behaviour
    repeat (2) @(posedge clk);
    #1;
    check("rst_cke", int'(cke), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_m_data", int'(m_data), 0);
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    reset  = 1'b0;
    #3;
    check("rel_cke_cycle1", int'(cke), 0);
    @(posedge clk);
    #2;
    check("rel_cke_cycle2", int'(cke), 1);

    // 2: back-to-back stream with a ready sink
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h11 + 8'(i), 1'b1);
      check("t2_cke", int'(cke), 1);
      check("t2_head", int'(m_data), int'(8'h11 + 8'(i)));
    end
    idle(3, 1'b1);
    exp_seq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    check_log("t2", exp_seq);

    // 3: fill to DEPTH with a stalled sink, then drain
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'hA0 + 8'(i), 1'b0);
      if (i == 3) begin
        check("t3_full_level", int'(level), 4);
        check("t3_full_cke", int'(cke), 0);
      end
    end
    check("t3_hold_level", int'(level), 4);
    step(1'b0, '0, 1'b1);
    check("t3_pop_cke", int'(cke), 1);
    check("t3_pop_level", int'(level), 3);
    idle(5, 1'b1);
    exp_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check_log("t3", exp_seq);

    // 4: bubbles are not stored
    step(1'b0, 8'h01, 1'b1);
    step(1'b1, 8'h02, 1'b1);
    step(1'b0, 8'h03, 1'b1);
    step(1'b1, 8'h04, 1'b1);
    idle(3, 1'b1);
    exp_seq = '{8'h02, 8'h04};
    check_log("t4", exp_seq);

    // 5: simultaneous push and pop at level 2
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    check("t5_level", int'(level), 2);
    step(1'b1, 8'h55, 1'b1);
    check("t5_level_same", int'(level), 2);
    idle(4, 1'b1);
    exp_seq = '{8'h31, 8'h32, 8'h55};
    check_log("t5", exp_seq);

    // push and pop together at DEPTH-1
    step(1'b1, 8'h41, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    step(1'b1, 8'h43, 1'b0);
    step(1'b1, 8'h44, 1'b1);
    check("t5b_level", int'(level), 3);
    check("t5b_cke", int'(cke), 1);
    idle(5, 1'b1);
    exp_seq = '{8'h41, 8'h42, 8'h43, 8'h44};
    check_log("t5b", exp_seq);

    // 6: reset mid-operation discards queued data
    step(1'b1, 8'h61, 1'b0);
    step(1'b1, 8'h62, 1'b0);
    step(1'b1, 8'h63, 1'b0);
    check("t6_level_pre", int'(level), 3);
    reset = 1'b1;
    step(1'b0, '0, 1'b0);
    reset = 1'b0;
    check("t6_level", int'(level), 0);
    check("t6_m_valid", int'(m_valid), 0);
    check("t6_cke", int'(cke), 0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 8'h77, 1'b0);
    check("t6_head", int'(m_data), int'(8'h77));
    idle(3, 1'b1);
    exp_seq = '{8'h77};
    check_log("t6", exp_seq);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
